// File: rtl/nic_link_arbiter.sv
// Round-robin link arbiter between NIC output buffers and the router link; captures the
// granted flit one cycle after its grant and routes one-hot VC credits back to their owners.
// Optional counters are enabled with the NIC_LINK_ARB_STATS_EN macro.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module nic_link_arbiter #(
  parameter int unsigned N_OUT_BUFFERS = 4,
  parameter int unsigned N_BITS_VC_ID  = 3,
  parameter int unsigned N_BITS_BUF_ID = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_OUT_BUFFERS-1:0]               r_la_i,
  output logic [N_OUT_BUFFERS-1:0]               g_la_o,
  input  logic [N_OUT_BUFFERS*`FLIT_WIDTH-1:0]   flit_i,
  input  logic [N_OUT_BUFFERS-1:0]               is_valid_i,
  input  logic [N_OUT_BUFFERS*N_BITS_VC_ID-1:0]  vc_id_i,
  input  logic [N_OUT_BUFFERS-1:0]               free_slot_i,
  input  logic                                   link_en_i,
  output logic [`FLIT_WIDTH-1:0]                 flit_o,
  output logic                                   is_valid_o,
  input  logic [N_BITS_VC_ID-1:0]                credit_i,
  output logic [N_OUT_BUFFERS-1:0]               credit_o,
`ifdef NIC_LINK_ARB_STATS_EN
  output logic [15:0]                            flit_count_o,
  output logic [15:0]                            stall_count_o,
`endif
  output logic                                   err_o
);

  localparam int unsigned FW = `FLIT_WIDTH;
  localparam int unsigned NB = N_OUT_BUFFERS;
  localparam int unsigned VW = N_BITS_VC_ID;
  localparam int unsigned BW = N_BITS_BUF_ID;

  logic [BW-1:0] rr_ptr_q, rr_ptr_d;
  logic          grant_pending_q, grant_pending_d;
  logic [BW-1:0] grant_idx_q, grant_idx_d;
  logic [FW-1:0] flit_q, flit_d;
  logic          is_valid_q, is_valid_d;
  logic [NB-1:0] credit_q, credit_d;
  logic          err_q, err_d;

  logic          grant_found;
  logic [BW-1:0] grant_sel;

  // Lowest requester at or above the pointer wins; otherwise the lowest below it (wrap).
  always_comb begin
    grant_found = 1'b0;
    grant_sel   = '0;
    g_la_o      = '0;
    if (!rst && link_en_i && !grant_pending_q) begin
      for (int i = int'(NB) - 1; i >= 0; i--) begin
        if (r_la_i[i] && (BW'(i) < rr_ptr_q)) begin
          grant_found = 1'b1;
          grant_sel   = BW'(i);
        end
      end
      for (int i = int'(NB) - 1; i >= 0; i--) begin
        if (r_la_i[i] && (BW'(i) >= rr_ptr_q)) begin
          grant_found = 1'b1;
          grant_sel   = BW'(i);
        end
      end
    end
    for (int i = 0; i < int'(NB); i++) begin
      g_la_o[i] = grant_found && (grant_sel == BW'(i));
    end
  end

  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    grant_pending_d = grant_found;
    grant_idx_d     = grant_idx_q;
    flit_d          = flit_q;
    is_valid_d      = 1'b0;
    credit_d        = '0;
    err_d           = err_q;

    if (grant_found) begin
      grant_idx_d = grant_sel;
      rr_ptr_d    = (grant_sel == BW'(NB - 1)) ? '0 : grant_sel + BW'(1);
    end

    // Capture the flit of the buffer granted last cycle; a missing valid is a protocol error.
    if (grant_pending_q) begin
      if (is_valid_i[grant_idx_q]) begin
        is_valid_d = 1'b1;
        for (int i = 0; i < int'(NB); i++) begin
          if (grant_idx_q == BW'(i)) flit_d = flit_i[i*FW +: FW];
        end
      end else begin
        err_d = 1'b1;
      end
    end

    for (int i = 0; i < int'(NB); i++) begin
      if (is_valid_i[i] && !(grant_pending_q && (grant_idx_q == BW'(i)))) err_d = 1'b1;
    end

    for (int i = 0; i < int'(NB); i++) begin
      if (!free_slot_i[i] && ((vc_id_i[i*VW +: VW] & credit_i) != '0)) credit_d[i] = 1'b1;
    end
    if ((credit_i != '0) && (credit_d == '0)) err_d = 1'b1;
    if ((credit_i & (credit_i - VW'(1))) != '0) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q        <= '0;
      grant_pending_q <= 1'b0;
      grant_idx_q     <= '0;
      flit_q          <= '0;
      is_valid_q      <= 1'b0;
      credit_q        <= '0;
      err_q           <= 1'b0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      grant_pending_q <= grant_pending_d;
      grant_idx_q     <= grant_idx_d;
      flit_q          <= flit_d;
      is_valid_q      <= is_valid_d;
      credit_q        <= credit_d;
      err_q           <= err_d;
    end
  end

  assign flit_o     = flit_q;
  assign is_valid_o = is_valid_q;
  assign credit_o   = credit_q;
  assign err_o      = err_q;

`ifdef NIC_LINK_ARB_STATS_EN
  logic [15:0] flit_count_q, flit_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  // Flit count wraps; stall count saturates.
  always_comb begin
    flit_count_d  = flit_count_q + 16'(is_valid_q);
    stall_count_d = stall_count_q;
    if ((r_la_i != '0) && !grant_found && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      flit_count_q  <= flit_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign flit_count_o  = flit_count_q;
  assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_nic_link_arbiter.sv
// Self-checking bench for nic_link_arbiter: cycle-level reference model plus directed literals.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif

module tb_nic_link_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned VCW = 3;
  localparam int unsigned BW  = 2;
  localparam int unsigned FW  = `FLIT_WIDTH;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    r_la_i, g_la_o, is_valid_i, free_slot_i, credit_o;
  logic [N*FW-1:0] flit_i;
  logic [N*VCW-1:0] vc_id_i;
  logic            link_en_i, is_valid_o, err_o;
  logic [FW-1:0]   flit_o;
  logic [VCW-1:0]  credit_i;
`ifdef NIC_LINK_ARB_STATS_EN
  logic [15:0]     flit_count_o, stall_count_o;
`endif

  nic_link_arbiter #(.N_OUT_BUFFERS(N), .N_BITS_VC_ID(VCW), .N_BITS_BUF_ID(BW)) dut (
    .clk(clk), .rst(rst), .r_la_i(r_la_i), .g_la_o(g_la_o), .flit_i(flit_i),
    .is_valid_i(is_valid_i), .vc_id_i(vc_id_i), .free_slot_i(free_slot_i),
    .link_en_i(link_en_i), .flit_o(flit_o), .is_valid_o(is_valid_o),
    .credit_i(credit_i), .credit_o(credit_o),
`ifdef NIC_LINK_ARB_STATS_EN
    .flit_count_o(flit_count_o), .stall_count_o(stall_count_o),
`endif
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  int            m_ptr, m_pidx, m_fc, m_stall;
  bit            m_pending, m_valid, m_err;
  logic [FW-1:0] m_flit;
  logic [N-1:0]  m_credit;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_pidx = 0; m_pending = 0; m_valid = 0; m_err = 0;
    m_flit = '0; m_credit = '0; m_fc = 0; m_stall = 0;
  endtask

  function automatic int model_grant();
    if (rst || !link_en_i || m_pending) return -1;
    for (int k = 0; k < int'(N); k++) begin
      int j;
      j = (m_ptr + k) % int'(N);
      if (r_la_i[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic compare_all();
    check("g_la", g_la_o, onehot(model_grant()));
    check("is_valid", is_valid_o, m_valid);
    check("flit", flit_o, m_flit);
    check("credit", credit_o, m_credit);
    check("err", err_o, m_err);
`ifdef NIC_LINK_ARB_STATS_EN
    check("flit_count", flit_count_o, m_fc);
    check("stall_count", stall_count_o, m_stall);
`endif
  endtask

  // Advance the model by one clock using the inputs driven for this cycle.
  task automatic end_cycle();
    int gi, owners, ones;
    bit nv, ne;
    logic [FW-1:0] nf;
    logic [N-1:0] nc;
    gi = model_grant();
    nv = 0; nf = m_flit; ne = m_err; nc = '0; owners = 0; ones = 0;
    if (m_pending) begin
      if (is_valid_i[m_pidx]) begin nv = 1; nf = flit_i[m_pidx*FW +: FW]; end
      else ne = 1;
    end
    for (int i = 0; i < int'(N); i++)
      if (is_valid_i[i] && !(m_pending && i == m_pidx)) ne = 1;
    for (int i = 0; i < int'(N); i++)
      if (!free_slot_i[i] && ((vc_id_i[i*VCW +: VCW] & credit_i) != 0)) begin nc[i] = 1; owners++; end
    for (int b = 0; b < int'(VCW); b++) ones += int'(credit_i[b]);
    if (ones > 0 && owners == 0) ne = 1;
    if (ones > 1) ne = 1;
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (m_valid) m_fc = (m_fc + 1) % 65536;
      if (r_la_i != 0 && gi < 0 && m_stall < 65535) m_stall++;
      m_valid = nv; m_flit = nf; m_err = ne; m_credit = nc;
      if (gi >= 0) begin m_pending = 1; m_pidx = gi; m_ptr = (gi + 1) % int'(N); end
      else m_pending = 0;
    end
    @(negedge clk);
  endtask

  task automatic step();
    #1 compare_all();
    end_cycle();
  endtask

  task automatic set_idle();
    r_la_i = '0; is_valid_i = '0; flit_i = '0; free_slot_i = '1;
    vc_id_i = {N{3'b001}}; credit_i = '0; link_en_i = 1'b1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop immediately.
  task automatic do_reset();
    #3 rst = 1'b1;
    #1 model_reset();
    compare_all();
    check("rst_g_la", g_la_o, 0);
    check("rst_valid", is_valid_o, 0);
    check("rst_flit", flit_o, 0);
    check("rst_credit", credit_o, 0);
    check("rst_err", err_o, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] exp_g [5];
    logic [FW-1:0] fv;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b0;
    model_reset();
    set_idle();
    @(negedge clk);
    do_reset();

    // Full request mask: strict rotation, one flit every two cycles
    for (int n = 0; n < 5; n++) begin
      r_la_i = 4'b1111; is_valid_i = '0;
      #1 compare_all();
      check("rr_grant", g_la_o, exp_g[n]);
      if (n > 0) begin
        fv = FW'(32'hF000_0000) | FW'((n - 1) << 8) | FW'($clog2(exp_g[n-1]));
        check("rr_flit", flit_o, fv);
        check("rr_valid", is_valid_o, 1);
      end
      end_cycle();
      is_valid_i = exp_g[n];
      for (int i = 0; i < int'(N); i++) flit_i[i*FW +: FW] = FW'(32'hF000_0000) | FW'(n << 8) | FW'(i);
      #1 compare_all();
      check("rr_pending_g", g_la_o, 0);
      end_cycle();
    end
    is_valid_i = '0; r_la_i = '0;
    #1 compare_all();
    check("rr_last_flit", flit_o, FW'(32'hF000_0400));
    end_cycle();

    // Wrap-around: pointer moved to 2, then mask 1010
    r_la_i = 4'b0010;
    #1 compare_all(); check("wrap_setup", g_la_o, 4'b0010); end_cycle();
    r_la_i = '0; is_valid_i = 4'b0010; step();
    r_la_i = 4'b1010; is_valid_i = '0;
    #1 compare_all(); check("wrap_hi", g_la_o, 4'b1000); end_cycle();
    is_valid_i = 4'b1000; step();
    is_valid_i = '0;
    #1 compare_all(); check("wrap_lo", g_la_o, 4'b0010); end_cycle();
    r_la_i = '0; is_valid_i = 4'b0010; step();
    is_valid_i = '0;

    // Credit routing to buffer 1, then an unowned credit
    free_slot_i = 4'b1101; vc_id_i = {3'b001, 3'b001, 3'b100, 3'b001};
    credit_i = 3'b100; step();
    credit_i = '0;
    #1 compare_all(); check("credit_owner", credit_o, 4'b0010); check("credit_err0", err_o, 0); end_cycle();
    #1 compare_all(); check("credit_pulse", credit_o, 4'b0000); end_cycle();
    credit_i = 3'b001; step();
    credit_i = '0;
    #1 compare_all(); check("credit_drop", credit_o, 4'b0000); check("credit_drop_err", err_o, 1); end_cycle();

    // Missing valid after a grant, then an unsolicited valid
    set_idle();
    do_reset();
    r_la_i = 4'b0100;
    #1 compare_all(); check("nv_grant", g_la_o, 4'b0100); end_cycle();
    r_la_i = '0; step();
    #1 compare_all(); check("nv_valid", is_valid_o, 0); check("nv_err", err_o, 1); end_cycle();
    do_reset();
    is_valid_i = 4'b1000; step();
    is_valid_i = '0;
    #1 compare_all(); check("unsol_err", err_o, 1); end_cycle();
    do_reset();

    // Link disabled blocks grants
    link_en_i = 1'b0; r_la_i = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #1 compare_all(); check("link_off", g_la_o, 0); end_cycle();
    end
    link_en_i = 1'b1; r_la_i = '0;
`ifdef NIC_LINK_ARB_STATS_EN
    #1 check("stall_lit", stall_count_o, 3);
    end_cycle();
    do_reset();
    for (int n = 0; n < 5; n++) begin
      r_la_i = 4'b0001; is_valid_i = '0; step();
      is_valid_i = 4'b0001; step();
    end
    r_la_i = '0; is_valid_i = '0; step(); step();
    #1 check("flit_count_lit", flit_count_o, 5);
    end_cycle();
`endif

    // Randomized segments, each opened by a mid-cycle asynchronous reset
    for (int seg = 0; seg < 6; seg++) begin
      do_reset();
      for (int c = 0; c < 400; c++) begin
        int r;
        link_en_i = ($urandom_range(0, 99) < 85);
        r_la_i = N'($urandom);
        is_valid_i = '0;
        if (m_pending && $urandom_range(0, 99) < 95) is_valid_i[m_pidx] = 1'b1;
        if ($urandom_range(0, 99) < 2) is_valid_i[$urandom_range(0, N-1)] = 1'b1;
        for (int i = 0; i < int'(N); i++) begin
          flit_i[i*FW +: FW] = FW'($urandom);
          vc_id_i[i*VCW +: VCW] = VCW'(3'b001 << $urandom_range(0, 2));
        end
        free_slot_i = N'($urandom);
        r = $urandom_range(0, 99);
        if (r < 30) credit_i = VCW'(3'b001 << $urandom_range(0, 2));
        else if (r < 33) credit_i = VCW'($urandom);
        else credit_i = '0;
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
